// File: rtl/spi_ram_ctrl_if.sv
// Word-level link between the SPI slave and the command-decoding RAM.
// The SPI slave drives the command word and its valid level. The RAM returns
// read data together with a valid window.
interface spi_ram_ctrl_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;

  // SPI slave side: issues commands, consumes read data
  modport master (
    output din,
    output rx_valid,
    input  dout,
    input  tx_valid
  );

  // RAM side: consumes commands, returns read data
  modport slave (
    input  din,
    input  rx_valid,
    output dout,
    output tx_valid
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM that sits behind an SPI slave.
// Each rising edge of rx_valid accepts one 10-bit word, and bits [9:8] of
// that word select the command:
//   00 load write address, 01 write data, 10 load read address,
//   11 read data. A read-data command drives dout and holds tx_valid high
//   for TX_HOLD cycles so the slave can serialise the byte.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int TX_HOLD   = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_ram_ctrl_if.slave       bus
);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;
  localparam logic [3:0] TX_LOAD    = 4'(TX_HOLD);

  logic                 rx_valid_q;
  logic                 rx_edge;
  logic [1:0]           opcode;
  logic [7:0]           payload;
  logic [ADDR_SIZE-1:0] addr_field;

  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [7:0]           mem [MEM_DEPTH];

  logic [7:0]           dout_r;
  logic                 tx_valid_r;
  logic [3:0]           tx_cnt;

  // The slave holds rx_valid high for many cycles per word. Only the
  // low-to-high transition counts, so a held level is a single command.
  assign rx_edge    = bus.rx_valid & ~rx_valid_q;
  assign opcode     = bus.din[9:8];
  assign payload    = bus.din[7:0];
  assign addr_field = bus.din[ADDR_SIZE-1:0];

  // Register rx_valid for edge detection. It resets to 0, so a level that is
  // already high at reset release counts as a fresh word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= bus.rx_valid;
    end
  end

  // Address registers. They change only on their own opcode and do not
  // auto-increment, so repeated data commands reuse the same location.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
    end else if (rx_edge) begin
      if (opcode == OP_WR_ADDR) begin
        wr_addr <= addr_field;
      end
      if (opcode == OP_RD_ADDR) begin
        rd_addr <= addr_field;
      end
    end
  end

  // Storage array. It has no reset, so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (rx_edge && (opcode == OP_WR_DATA)) begin
      mem[wr_addr] <= payload;
    end
  end

  // Read response window. A read-data word captures mem[rd_addr] and opens
  // a TX_HOLD-cycle window, restarting it if one is already open. Any other
  // accepted word closes the window at once. Otherwise the counter runs down
  // and tx_valid falls on the 1 -> 0 step. dout keeps the last byte read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r     <= 8'h00;
      tx_valid_r <= 1'b0;
      tx_cnt     <= 4'd0;
    end else if (rx_edge) begin
      if (opcode == OP_RD_DATA) begin
        dout_r     <= mem[rd_addr];
        tx_valid_r <= 1'b1;
        tx_cnt     <= TX_LOAD;
      end else begin
        tx_valid_r <= 1'b0;
        tx_cnt     <= 4'd0;
      end
    end else if (tx_cnt != 4'd0) begin
      tx_cnt <= tx_cnt - 4'd1;
      if (tx_cnt == 4'd1) begin
        tx_valid_r <= 1'b0;
      end
    end
  end

  assign bus.dout     = dout_r;
  assign bus.tx_valid = tx_valid_r;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed testbench for spi_ram_ctrl. A table of single-word commands is
// run with the expected outputs after each accepting edge, followed by
// hand-written sequences for the window length, window interrupts, the
// held rx_valid level, the default addresses and asynchronous reset.
module tb_spi_ram_ctrl;

  logic clk;
  logic rst_n;

  spi_ram_ctrl_if bus_if ();

  spi_ram_ctrl #(
    .MEM_DEPTH(256),
    .ADDR_SIZE(8),
    .TX_HOLD  (9)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [9:0] din;
    logic       exp_tx;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: present one word for one clock, then drop rx_valid.
  // Returns at the negedge right after the accepting edge.
  task automatic pulse(input logic [9:0] w);
    bus_if.din      = w;
    bus_if.rx_valid = 1'b1;
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
  endtask

  // Counts consecutive negedge samples with tx_valid high, starting now.
  task automatic count_window(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus_if.tx_valid !== 1'b1) break;
      n++;
      @(negedge clk);
    end
  endtask

  int win;

  initial begin
    n_checks = 0;
    n_fail   = 0;

    tbl[0]  = '{10'h03C, 1'b0, 8'h77};
    tbl[1]  = '{10'h1A5, 1'b0, 8'h77};
    tbl[2]  = '{10'h23C, 1'b0, 8'h77};
    tbl[3]  = '{10'h300, 1'b1, 8'hA5};
    tbl[4]  = '{10'h007, 1'b0, 8'hA5};
    tbl[5]  = '{10'h101, 1'b0, 8'hA5};
    tbl[6]  = '{10'h102, 1'b0, 8'hA5};
    tbl[7]  = '{10'h207, 1'b0, 8'hA5};
    tbl[8]  = '{10'h3FF, 1'b1, 8'h02};
    tbl[9]  = '{10'h300, 1'b1, 8'h02};
    tbl[10] = '{10'h23C, 1'b0, 8'h02};
    tbl[11] = '{10'h300, 1'b1, 8'hA5};
    tbl[12] = '{10'h010, 1'b0, 8'hA5};
    tbl[13] = '{10'h15A, 1'b0, 8'hA5};
    tbl[14] = '{10'h210, 1'b0, 8'hA5};
    tbl[15] = '{10'h3C3, 1'b1, 8'h5A};

    // Reset with a write-data word already pending on a high rx_valid level
    rst_n           = 1'b0;
    bus_if.din      = 10'h177;
    bus_if.rx_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_tx_valid", 32'(bus_if.tx_valid), 32'h0);
    check("reset_dout", 32'(bus_if.dout), 32'h00);
    rst_n = 1'b1;
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
    @(negedge clk);
    pulse(10'h300);
    check("default_addr_read_tx", 32'(bus_if.tx_valid), 32'h1);
    check("default_addr_read_dout", 32'(bus_if.dout), 32'h77);
    @(negedge clk);

    // Table of single-word commands
    for (int i = 0; i < 16; i++) begin
      pulse(tbl[i].din);
      check($sformatf("vec%0d_tx_valid", i), 32'(bus_if.tx_valid), 32'(tbl[i].exp_tx));
      check($sformatf("vec%0d_dout", i), 32'(bus_if.dout), 32'(tbl[i].exp_dout));
      @(negedge clk);
    end

    // Full window: read mem[0x3C]=A5, the window must last exactly 9 cycles
    pulse(10'h23C);
    @(negedge clk);
    pulse(10'h300);
    count_window(win);
    check("window_len", 32'(win), 32'd9);
    check("dout_held_after_window", 32'(bus_if.dout), 32'hA5);

    // Interrupt the window with a write-address word at window cycle 4
    pulse(10'h300);
    repeat (3) @(negedge clk);
    check("window_active_before_irq", 32'(bus_if.tx_valid), 32'h1);
    pulse(10'h001);
    check("irq_00_clears_tx", 32'(bus_if.tx_valid), 32'h0);
    @(negedge clk);
    check("irq_00_stays_clear", 32'(bus_if.tx_valid), 32'h0);

    // Interrupt with another read: the window restarts for 9 full cycles
    pulse(10'h300);
    repeat (3) @(negedge clk);
    pulse(10'h300);
    count_window(win);
    check("irq_11_restart_len", 32'(win), 32'd9);

    // Held rx_valid level: one write of 0x11 to address 5, 0x22 ignored
    pulse(10'h005);
    @(negedge clk);
    bus_if.din      = 10'h111;
    bus_if.rx_valid = 1'b1;
    repeat (10) @(negedge clk);
    bus_if.din = 10'h122;
    repeat (10) @(negedge clk);
    bus_if.rx_valid = 1'b0;
    @(negedge clk);
    pulse(10'h205);
    @(negedge clk);
    pulse(10'h300);
    check("level_hold_dout", 32'(bus_if.dout), 32'h11);
    @(negedge clk);

    // Asynchronous reset in the middle of a window
    pulse(10'h300);
    @(negedge clk);
    check("pre_reset_tx_valid", 32'(bus_if.tx_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_tx_valid", 32'(bus_if.tx_valid), 32'h0);
    check("async_reset_dout", 32'(bus_if.dout), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_reset_tx_idle", 32'(bus_if.tx_valid), 32'h0);
    // Both addresses must be back at 0: write then read with no address words
    pulse(10'h199);
    @(negedge clk);
    pulse(10'h300);
    check("post_reset_addr0_dout", 32'(bus_if.dout), 32'h99);
    count_window(win);
    check("post_reset_window_len", 32'(win), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Command-decoding single-port RAM that sits directly downstream of the SPI slave. It consumes the slave's 10-bit `rx_data`/`rx_valid` words and decodes bits [9:8] as write-address, write-data, read-address or read-data commands. It answers read-data commands with an 8-bit `dout`/`tx_valid` pair that the slave serialises onto MISO.

## Interface
- `MEM_DEPTH`, 256, number of 8-bit words; must equal 2**ADDR_SIZE.
- `ADDR_SIZE`, 8, address width; legal range 1..8. Address bits are taken from din[ADDR_SIZE-1:0]; higher din bits are ignored.
- `TX_HOLD`, 9, number of cycles tx_valid stays high per read-data response; legal range 1..15.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `din`  input  10  command word from SPI slave rx_data; [9:8] opcode, [7:0] payload.
- `rx_valid`  input  1  word-valid level from SPI slave; may stay high for many cycles per word.
- `dout`  output  8  read data to SPI slave tx_data.
- `tx_valid`  output  1  read data valid to SPI slave.

## Operation
- Command acceptance: a command is accepted only on a rising edge of rx_valid. rx_edge = rx_valid & ~rx_valid_q, where rx_valid_q is rx_valid registered. rx_valid held high produces exactly one acceptance. Each new acceptance requires rx_valid to drop for at least one cycle first.
- Opcode decode on the accepting edge:
  - 2'b00: wr_addr <= din[ADDR_SIZE-1:0]
  - 2'b01: mem[wr_addr] <= din[7:0]
  - 2'b10: rd_addr <= din[ADDR_SIZE-1:0]
  - 2'b11: dout <= mem[rd_addr]; start tx window. Payload din[7:0] is ignored.
- Addresses are independent. wr_addr and rd_addr persist across any number of data commands; there is no auto-increment. Repeated 01 commands overwrite the same location.
- A read-data command with no prior read-address command since reset reads address 0.
- The tx window is driven by tx_cnt (4 bits):
  - A read-data acceptance loads tx_cnt = TX_HOLD and asserts tx_valid.
  - tx_cnt decrements each cycle while nonzero. tx_valid drops on the edge where tx_cnt goes 1 -> 0.
- A new acceptance of any opcode during an active window:
  - opcode 11 restarts the window at TX_HOLD with the new dout.
  - any other opcode clears tx_valid and tx_cnt on that same edge.
- dout holds its last read value after tx_valid drops. It changes only on a read-data acceptance.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values (asynchronous, immediate): tx_valid = 0, dout = 8'h00, wr_addr = 0, rd_addr = 0, tx_cnt = 0, rx_valid_q = 0. RAM contents are retained.
- rx_valid high in the first cycle after reset release counts as a rising edge, so the command is accepted.
- Write latency: with the accepting edge at cycle k, mem is updated at edge k. A read-data command accepted at any later edge returns the new value.
- Read latency: with acceptance at edge k, dout and tx_valid are valid from edge k until edge k+TX_HOLD. tx_valid is high for exactly TX_HOLD cycles.
- rx_valid dropping during a tx window has no effect on the window.
- Reset asserted mid-window: tx_valid falls immediately, with no completion of the remaining cycles.
- A single edge holds at most one command; no write/read collision on the same cycle is possible.

## Test plan
- Reset: drive rst_n low mid-window with tx_valid = 1 -> tx_valid and dout go to 0 asynchronously, before the next clk edge; all counters/addresses are 0 after release.
- Write/read: send 00_0x3C, then 01_0xA5, then 10_0x3C, then 11_0x00 -> dout = 8'hA5 and tx_valid high for exactly 9 cycles starting at the accepting edge.
- Level hold: hold rx_valid high 20 cycles with din = 01_0x11 after wr_addr = 5, then change din to 01_0x22 while rx_valid is still high -> mem[5] = 8'h11; no second write occurs.
- Default address: after reset, write 01_0x77 (goes to address 0), then send 11 with no read-address command -> dout = 8'h77.
- Window interrupt: issue a read (tx window active), then accept 00_0x01 at window cycle 4 -> tx_valid clears at that edge. Repeat with 11 instead of 00 -> window restarts and is 9 cycles long from the new edge.
- Address persistence: with wr_addr = 7, write 0x01 then 0x02; with rd_addr = 7, read twice -> both reads return 8'h02.
